// File: rtl/i2c_write_master.sv
// Bit-level I2C master that performs one 16-bit-address / 16-bit-data SGTL5000 register write per request.
// Build option: define I2C_NACK_RETRY_EN to resend a NACKed frame up to three more times before flagging nack_error.
module i2c_write_master #(
    parameter int unsigned QTR_DIV       = 125,
    parameter logic [6:0]  DEV_ADDR      = 7'h0A,
    parameter int unsigned BUS_FREE_QTRS = 4
) (
    input  logic        clk50,
    input  logic        reset_n,
    input  logic [15:0] i2c_address,
    input  logic [15:0] i2c_data,
    input  logic        interface_enable,
    output logic        interface_acknowledge,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        sda_in,
    output logic        nack_error
);

    localparam int DIV_W  = $clog2(QTR_DIV);
    localparam int HOLD_W = $clog2(BUS_FREE_QTRS + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(QTR_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(BUS_FREE_QTRS - 1);

    typedef enum logic [2:0] {
        IDLE_HOLD,
        IDLE,
        START,
        BIT,
        STOP
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [DIV_W-1:0]    div_cnt;
    logic [1:0]          qcnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [3:0]          bit_idx;
    logic [2:0]          byte_idx;
    logic [39:0]         frame;
    logic [7:0]          cur_byte;
    logic                cur_bit;
    logic                qtick;
    logic                accept;
    logic                ack_bit;
    logic                bit_end;
    logic                nack_now;
    logic                retry_ok;
    logic                retry_go;
    logic                scl_nxt;
    logic                sda_nxt;

    assign qtick                 = (div_cnt == DIV_LAST);
    assign accept                = (state == IDLE) && interface_enable;
    assign ack_bit               = (bit_idx == 4'd8);
    assign bit_end               = (state == BIT) && qtick && (qcnt == 2'd3);
    assign nack_now              = bit_end && ack_bit && sda_in;
    assign interface_acknowledge = (state == IDLE);

    always_comb begin
        cur_byte = frame[7:0];
        case (byte_idx)
            3'd0:    cur_byte = frame[39:32];
            3'd1:    cur_byte = frame[31:24];
            3'd2:    cur_byte = frame[23:16];
            3'd3:    cur_byte = frame[15:8];
            default: cur_byte = frame[7:0];
        endcase
        cur_bit = cur_byte[3'd7 - bit_idx[2:0]];
    end

    // SDA is held for the first cycle of BIT/STOP q0 so it only moves once SCL is already low.
    always_comb begin
        state_nxt = state;
        scl_nxt   = 1'b0;
        sda_nxt   = 1'b0;
        case (state)
            IDLE_HOLD: begin
                if (qtick && (hold_cnt == HOLD_LAST))
                    state_nxt = retry_go ? START : IDLE;
            end
            IDLE: begin
                if (interface_enable)
                    state_nxt = START;
            end
            START: begin
                sda_nxt = (qcnt == 2'd1);
                if (qtick && (qcnt == 2'd1))
                    state_nxt = BIT;
            end
            BIT: begin
                scl_nxt = ~qcnt[1];
                if ((qcnt == 2'd0) && (div_cnt == '0))
                    sda_nxt = sda_oe;
                else
                    sda_nxt = ~ack_bit & ~cur_bit;
                if (bit_end && ack_bit && (sda_in || (byte_idx == 3'd4)))
                    state_nxt = STOP;
            end
            STOP: begin
                scl_nxt = (qcnt == 2'd0);
                if ((qcnt == 2'd0) && (div_cnt == '0))
                    sda_nxt = sda_oe;
                else
                    sda_nxt = (qcnt != 2'd2);
                if (qtick && (qcnt == 2'd2))
                    state_nxt = IDLE_HOLD;
            end
            default: state_nxt = IDLE_HOLD;
        endcase
    end

    always_ff @(posedge clk50) begin
        if (!reset_n) begin
            state      <= IDLE_HOLD;
            div_cnt    <= '0;
            qcnt       <= '0;
            hold_cnt   <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            frame      <= '0;
            scl_oe     <= 1'b0;
            sda_oe     <= 1'b0;
            nack_error <= 1'b0;
        end else begin
            state  <= state_nxt;
            scl_oe <= scl_nxt;
            sda_oe <= sda_nxt;
            div_cnt <= (accept || qtick) ? '0 : div_cnt + DIV_W'(1);

            if (state_nxt != state)
                qcnt <= '0;
            else if (qtick)
                qcnt <= qcnt + 2'd1;

            if (state != IDLE_HOLD)
                hold_cnt <= '0;
            else if (qtick)
                hold_cnt <= hold_cnt + HOLD_W'(1);

            if (state != BIT) begin
                bit_idx  <= '0;
                byte_idx <= '0;
            end else if (bit_end) begin
                if (ack_bit) begin
                    bit_idx  <= '0;
                    byte_idx <= byte_idx + 3'd1;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                end
            end

            if (accept)
                frame <= {DEV_ADDR, 1'b0, i2c_address, i2c_data};

            if (nack_now && !retry_ok)
                nack_error <= 1'b1;
        end
    end

`ifdef I2C_NACK_RETRY_EN
    logic [1:0] retry_cnt;
    logic       retry_pend;

    assign retry_ok = (retry_cnt != 2'd3);
    assign retry_go = retry_pend;

    // retry_pend steers the end of the bus-free hold straight back into START instead of IDLE.
    always_ff @(posedge clk50) begin
        if (!reset_n) begin
            retry_cnt  <= '0;
            retry_pend <= 1'b0;
        end else if (accept) begin
            retry_cnt  <= '0;
            retry_pend <= 1'b0;
        end else if (nack_now && retry_ok) begin
            retry_cnt  <= retry_cnt + 2'd1;
            retry_pend <= 1'b1;
        end else if ((state == IDLE_HOLD) && (state_nxt == START)) begin
            retry_pend <= 1'b0;
        end
    end
`else
    assign retry_ok = 1'b0;
    assign retry_go = 1'b0;
`endif

endmodule
